// File: rtl/multicore_ctrl_pkg.sv
// Shared definitions for the Vicuna multicore controller: register offsets,
// CTRL bit-field layout and the per-core sequencing state.
package multicore_ctrl_pkg;

    localparam logic [11:0] OffCtrl         = 12'h000;
    localparam logic [11:0] OffStatus       = 12'h004;
    localparam logic [11:0] OffIntrState    = 12'h008;
    localparam logic [11:0] OffIntrEnable   = 12'h00C;
    localparam logic [11:0] OffBootAddrBase = 12'h010;
    localparam logic [11:0] OffCyclesBase   = 12'h020;

    // CTRL: start bits at [NumCores-1:0], abort bits at [8+NumCores-1:8]
    localparam int unsigned CtrlStartBase = 0;
    localparam int unsigned CtrlAbortBase = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        DONE    = 2'd2
    } core_state_e;

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions used by the register port of multicore_ctrl.
// Field set and opcode encodings follow the TileLink Uncached Lightweight
// subset used on xbar_main (32-bit data, 8-bit source, no user bits).
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/multicore_ctrl_core_fsm.sv
// Sequencer for one Vicuna worker core: IDLE (held in reset) -> RUNNING
// (released) -> DONE (held in reset again, completion reported).
// Abort always wins over start and over a coincident done.
// Optional: MULTICORE_CTRL_CYCLE_CNT_EN adds a saturating RUNNING-cycle counter.
module multicore_ctrl_core_fsm
    import multicore_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        done_i,
    output core_state_e state_o,
    output logic        rst_no,
    output logic        done_evt_o
`ifdef MULTICORE_CTRL_CYCLE_CNT_EN
    ,
    output logic [31:0] cycles_o
`endif
);

    core_state_e state_q, state_d;

    // Next-state and completion event
    always_comb begin
        state_d    = state_q;
        done_evt_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (done_i) begin
                    state_d    = DONE;
                    done_evt_o = 1'b1;
                end
            end
            DONE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (start_i) begin
                    state_d = RUNNING;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;
    // Core runs only in RUNNING; DONE re-asserts reset so a restart is clean
    assign rst_no  = (state_q == RUNNING);

`ifdef MULTICORE_CTRL_CYCLE_CNT_EN
    logic [31:0] cycles_q, cycles_d;

    // Cycle counter next value: clear on entry to RUNNING, saturate while running
    always_comb begin
        cycles_d = cycles_q;
        if (state_q != RUNNING && state_d == RUNNING) begin
            cycles_d = '0;
        end else if (state_q == RUNNING && cycles_q != 32'hFFFF_FFFF) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    // Cycle counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles_o = cycles_q;
`endif

endmodule

// File: rtl/multicore_ctrl.sv
// Vicuna worker-core controller: TL-UL register device that holds each core
// in reset, programs its boot address, releases it on start and raises a
// level interrupt on completion.
// Optional: MULTICORE_CTRL_CYCLE_CNT_EN adds read-only CYCLES[i] at 0x20+4i.
// For NumCores > 4 the BOOT_ADDR window takes precedence over CYCLES decode.
module multicore_ctrl
    import multicore_ctrl_pkg::*;
#(
    parameter int unsigned NumCores        = 2,
    parameter logic [31:0] DefaultBootAddr = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  tlul_pkg::tl_h2d_t      tl_i,
    output tlul_pkg::tl_d2h_t      tl_o,
    input  logic [NumCores-1:0]    core_done_i,
    output logic [NumCores-1:0]    core_rst_no,
    output logic [NumCores*32-1:0] boot_addr_o,
    output logic                   irq_o
);

    logic                d_valid_q, d_valid_d;
    logic [2:0]          rsp_opcode_q;
    logic [1:0]          rsp_size_q;
    logic [7:0]          rsp_source_q;
    logic [31:0]         rsp_data_q;
    logic                rsp_error_q;

    logic [NumCores-1:0] intr_state_q, intr_state_d;
    logic [NumCores-1:0] intr_enable_q, intr_enable_d;
    logic                irq_q, irq_d;
    logic [31:0]         boot_q [NumCores];
    logic [31:0]         boot_d [NumCores];

    core_state_e         core_state [NumCores];
    logic [NumCores-1:0] done_evt;
    logic [NumCores-1:0] start_vec, abort_vec;
`ifdef MULTICORE_CTRL_CYCLE_CNT_EN
    logic [31:0]         cycles [NumCores];
`endif

    logic [11:0]         reg_off;
    logic                accept, is_rd, is_wr, req_err, wr_ok;
    logic                addr_hit, sel_ctrl, sel_istate, sel_ien;
    logic [NumCores-1:0] boot_hit;
    logic [31:0]         rdata, status_w;
    logic                unused_tl;

    assign reg_off   = tl_i.a_address[11:0];
    assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:12]};
    assign accept    = tl_i.a_valid & ~d_valid_q;
    assign is_rd     = (tl_i.a_opcode == tlul_pkg::Get);
    assign is_wr     = (tl_i.a_opcode == tlul_pkg::PutFullData) ||
                       (tl_i.a_opcode == tlul_pkg::PutPartialData);

    // Pack per-core states into the STATUS view
    always_comb begin
        status_w = '0;
        for (int i = 0; i < NumCores; i++) begin
            status_w[2*i +: 2] = core_state[i];
        end
    end

    // Address decode and read mux, evaluated on the request as presented
    always_comb begin
        addr_hit   = 1'b0;
        sel_ctrl   = 1'b0;
        sel_istate = 1'b0;
        sel_ien    = 1'b0;
        boot_hit   = '0;
        rdata      = '0;
        case (reg_off)
            OffCtrl: begin
                addr_hit = 1'b1;
                sel_ctrl = 1'b1;
            end
            OffStatus: begin
                addr_hit = 1'b1;
                rdata    = status_w;
            end
            OffIntrState: begin
                addr_hit   = 1'b1;
                sel_istate = 1'b1;
                rdata      = 32'(intr_state_q);
            end
            OffIntrEnable: begin
                addr_hit = 1'b1;
                sel_ien  = 1'b1;
                rdata    = 32'(intr_enable_q);
            end
            default: begin
                for (int i = 0; i < NumCores; i++) begin
                    if (reg_off == OffBootAddrBase + 12'(4*i)) begin
                        addr_hit    = 1'b1;
                        boot_hit[i] = 1'b1;
                        rdata       = boot_q[i];
                    end
                end
`ifdef MULTICORE_CTRL_CYCLE_CNT_EN
                if (!addr_hit) begin
                    for (int i = 0; i < NumCores; i++) begin
                        if (reg_off == OffCyclesBase + 12'(4*i)) begin
                            addr_hit = 1'b1;
                            rdata    = cycles[i];
                        end
                    end
                end
`endif
            end
        endcase
    end

    // Only full-word accesses with a known opcode to a mapped register are legal
    assign req_err = ~addr_hit | (tl_i.a_size != 2'd2) | (tl_i.a_mask != 4'hF) |
                     ~(is_rd | is_wr);
    assign wr_ok   = accept & is_wr & ~req_err;

    assign start_vec = (wr_ok && sel_ctrl) ? tl_i.a_data[CtrlStartBase +: NumCores] : '0;
    assign abort_vec = (wr_ok && sel_ctrl) ? tl_i.a_data[CtrlAbortBase +: NumCores] : '0;

    for (genvar i = 0; i < NumCores; i++) begin : g_core
        multicore_ctrl_core_fsm u_fsm (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .start_i    (start_vec[i]),
            .abort_i    (abort_vec[i]),
            .done_i     (core_done_i[i]),
            .state_o    (core_state[i]),
            .rst_no     (core_rst_no[i]),
            .done_evt_o (done_evt[i])
`ifdef MULTICORE_CTRL_CYCLE_CNT_EN
            ,
            .cycles_o   (cycles[i])
`endif
        );
        assign boot_addr_o[32*i +: 32] = boot_q[i];
    end

    // Register next-state: done-set beats W1C; BOOT_ADDR frozen while running
    always_comb begin
        intr_state_d  = intr_state_q;
        intr_enable_d = intr_enable_q;
        irq_d         = |(intr_state_q & intr_enable_q);
        if (wr_ok && sel_istate) begin
            intr_state_d = intr_state_q & ~tl_i.a_data[NumCores-1:0];
        end
        intr_state_d = intr_state_d | done_evt;
        if (wr_ok && sel_ien) begin
            intr_enable_d = tl_i.a_data[NumCores-1:0];
        end
        for (int i = 0; i < NumCores; i++) begin
            boot_d[i] = boot_q[i];
            if (wr_ok && boot_hit[i] && core_state[i] != RUNNING) begin
                boot_d[i] = {tl_i.a_data[31:2], 2'b00};
            end
        end
    end

    // Control and configuration registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            intr_state_q  <= '0;
            intr_enable_q <= '0;
            irq_q         <= 1'b0;
            for (int i = 0; i < NumCores; i++) begin
                boot_q[i] <= {DefaultBootAddr[31:2], 2'b00};
            end
        end else begin
            intr_state_q  <= intr_state_d;
            intr_enable_q <= intr_enable_d;
            irq_q         <= irq_d;
            for (int i = 0; i < NumCores; i++) begin
                boot_q[i] <= boot_d[i];
            end
        end
    end

    // Response valid: set on accept, held until the host takes it
    always_comb begin
        d_valid_d = d_valid_q;
        if (accept) begin
            d_valid_d = 1'b1;
        end else if (tl_i.d_ready) begin
            d_valid_d = 1'b0;
        end
    end

    // Response valid register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_valid_q <= 1'b0;
        end else begin
            d_valid_q <= d_valid_d;
        end
    end

    // Response payload, captured at accept and only observed while d_valid is high
    always_ff @(posedge clk_i) begin
        if (accept) begin
            rsp_opcode_q <= is_rd ? tlul_pkg::AccessAckData : tlul_pkg::AccessAck;
            rsp_size_q   <= tl_i.a_size;
            rsp_source_q <= tl_i.a_source;
            rsp_error_q  <= req_err;
            rsp_data_q   <= (is_rd && !req_err) ? rdata : 32'h0;
        end
    end

    // Drive the response channel
    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = d_valid_q;
        tl_o.d_opcode = rsp_opcode_q;
        tl_o.d_size   = rsp_size_q;
        tl_o.d_source = rsp_source_q;
        tl_o.d_data   = rsp_data_q;
        tl_o.d_error  = rsp_error_q;
        tl_o.a_ready  = ~d_valid_q;
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_multicore_ctrl.sv
// Self-checking bench for multicore_ctrl: directed scenarios plus randomized
// register traffic and core_done_i activity, compared against a behavioural
// model of the register map and per-core sequencing rules.
// Define MULTICORE_CTRL_CYCLE_CNT_EN for both bench and RTL to cover CYCLES.
module tb_multicore_ctrl;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    tlul_pkg::tl_h2d_t tl_i;
    tlul_pkg::tl_d2h_t tl_o;
    logic [1:0]        core_done_i;
    logic [1:0]        core_rst_no;
    logic [63:0]       boot_addr_o;
    logic              irq_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    multicore_ctrl #(
        .NumCores        (2),
        .DefaultBootAddr (32'h0000_0000)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .tl_i        (tl_i),
        .tl_o        (tl_o),
        .core_done_i (core_done_i),
        .core_rst_no (core_rst_no),
        .boot_addr_o (boot_addr_o),
        .irq_o       (irq_o)
    );

    // Behavioural model: state per core as 0 idle / 1 running / 2 done
    bit [1:0]  m_st   [2];
    bit [1:0]  m_is;
    bit [1:0]  m_ie;
    bit [31:0] m_boot [2];
    bit [31:0] m_cyc  [2];
    bit        m_irq;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the model; acc marks a request accepted on this edge
    function automatic void model_edge(input bit acc, input bit [2:0] op, input bit [11:0] off,
                                       input bit [31:0] wd, input bit [3:0] mask,
                                       input bit [1:0] sz, input bit [1:0] dn,
                                       output bit [31:0] rd, output bit er);
        bit [1:0] start, abort, w1c, setv, old;
        bit       hit, is_wr, is_rd;
        start = '0; abort = '0; w1c = '0; setv = '0; rd = '0; er = 1'b0;
        m_irq = |(m_is & m_ie);
        if (acc) begin
            is_wr = (op == 3'd0) || (op == 3'd1);
            is_rd = (op == 3'd4);
            hit   = 1'b1;
            case (off)
                12'h000: rd = 32'h0;
                12'h004: rd = {28'h0, m_st[1], m_st[0]};
                12'h008: rd = {30'h0, m_is};
                12'h00C: rd = {30'h0, m_ie};
                12'h010: rd = m_boot[0];
                12'h014: rd = m_boot[1];
`ifdef MULTICORE_CTRL_CYCLE_CNT_EN
                12'h020: rd = m_cyc[0];
                12'h024: rd = m_cyc[1];
`endif
                default: hit = 1'b0;
            endcase
            er = !hit || sz != 2'd2 || mask != 4'hF || !(is_wr || is_rd);
            if (er || !is_rd) rd = '0;
            if (!er && is_wr) begin
                case (off)
                    12'h000: begin start = wd[1:0]; abort = wd[9:8]; end
                    12'h008: w1c = wd[1:0];
                    12'h00C: m_ie = wd[1:0];
                    12'h010: if (m_st[0] != 2'd1) m_boot[0] = wd & 32'hFFFF_FFFC;
                    12'h014: if (m_st[1] != 2'd1) m_boot[1] = wd & 32'hFFFF_FFFC;
                    default: ;
                endcase
            end
        end
        for (int i = 0; i < 2; i++) begin
            old = m_st[i];
            if (old == 2'd0) begin
                if (start[i] && !abort[i]) m_st[i] = 2'd1;
            end else if (old == 2'd1) begin
                if (abort[i]) m_st[i] = 2'd0;
                else if (dn[i]) begin m_st[i] = 2'd2; setv[i] = 1'b1; end
            end else begin
                if (abort[i]) m_st[i] = 2'd0;
                else if (start[i]) m_st[i] = 2'd1;
            end
            if (old == 2'd1 && m_cyc[i] != 32'hFFFF_FFFF) m_cyc[i] = m_cyc[i] + 32'd1;
            if (old != 2'd1 && m_st[i] == 2'd1) m_cyc[i] = 32'd0;
        end
        m_is = (m_is & ~w1c) | setv;
    endfunction

    task automatic check_outputs();
        check_eq("core_rst_no", 64'(core_rst_no), 64'({m_st[1] == 2'd1, m_st[0] == 2'd1}));
        check_eq("boot_addr_o", boot_addr_o, {m_boot[1], m_boot[0]});
        check_eq("irq_o", 64'(irq_o), 64'(m_irq));
    endtask

    task automatic tick(input bit [1:0] dn);
        bit [31:0] r;
        bit        e;
        core_done_i = dn;
        @(posedge clk_i);
        model_edge(1'b0, 3'd0, 12'h0, 32'h0, 4'h0, 2'd0, dn, r, e);
        #1 check_outputs();
        @(negedge clk_i);
        core_done_i = 2'b00;
    endtask

    // One TL-UL transaction; response held for 'hold' cycles with d_ready low
    task automatic xfer(input bit [2:0] op, input bit [11:0] off, input bit [31:0] wd,
                        input bit [3:0] mask, input bit [1:0] sz, input bit [1:0] dn,
                        input int hold, output bit [31:0] rd_o, output bit err_o);
        bit [31:0] erd, r;
        bit        eer, e;
        bit [7:0]  src;
        src            = 8'($urandom);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_param   = 3'd0;
        tl_i.a_size    = sz;
        tl_i.a_source  = src;
        tl_i.a_address = {20'h0, off};
        tl_i.a_mask    = mask;
        tl_i.a_data    = wd;
        tl_i.d_ready   = (hold == 0);
        core_done_i    = dn;
        @(posedge clk_i);
        model_edge(1'b1, op, off, wd, mask, sz, dn, erd, eer);
        #1 check_outputs();
        @(negedge clk_i);
        tl_i.a_valid = 1'b0;
        core_done_i  = 2'b00;
        check_eq("d_valid", 64'(tl_o.d_valid), 64'd1);
        check_eq("a_ready_busy", 64'(tl_o.a_ready), 64'd0);
        check_eq("d_error", 64'(tl_o.d_error), 64'(eer));
        check_eq("d_data", 64'(tl_o.d_data), 64'(erd));
        check_eq("d_opcode", 64'(tl_o.d_opcode), (op == 3'd4) ? 64'd1 : 64'd0);
        check_eq("d_source", 64'(tl_o.d_source), 64'(src));
        check_eq("d_size", 64'(tl_o.d_size), 64'(sz));
        rd_o  = tl_o.d_data;
        err_o = tl_o.d_error;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk_i);
            model_edge(1'b0, 3'd0, 12'h0, 32'h0, 4'h0, 2'd0, 2'b00, r, e);
            #1 check_outputs();
            @(negedge clk_i);
            check_eq("hold_d_valid", 64'(tl_o.d_valid), 64'd1);
            check_eq("hold_a_ready", 64'(tl_o.a_ready), 64'd0);
        end
        tl_i.d_ready = 1'b1;
        @(posedge clk_i);
        model_edge(1'b0, 3'd0, 12'h0, 32'h0, 4'h0, 2'd0, 2'b00, r, e);
        #1 check_outputs();
        check_eq("d_valid_drop", 64'(tl_o.d_valid), 64'd0);
        check_eq("a_ready_free", 64'(tl_o.a_ready), 64'd1);
        @(negedge clk_i);
    endtask

    task automatic rd32(input bit [11:0] off, output bit [31:0] d);
        bit e;
        xfer(3'd4, off, 32'h0, 4'hF, 2'd2, 2'b00, 0, d, e);
    endtask

    task automatic wr32(input bit [11:0] off, input bit [31:0] wd);
        bit [31:0] d;
        bit        e;
        xfer(3'd0, off, wd, 4'hF, 2'd2, 2'b00, 0, d, e);
    endtask

    function automatic bit [1:0] rand_done();
        return {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit [31:0] d;
        bit        e;
        bit [11:0] offs [11];
        bit [11:0] off;
        bit [2:0]  op;
        bit [3:0]  mask;
        bit [1:0]  sz;
        bit [31:0] wd;

        offs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
                 12'h018, 12'h020, 12'h024, 12'h040, 12'h002};
        tl_i         = '0;
        tl_i.d_ready = 1'b1;
        core_done_i  = 2'b00;
        rst_ni       = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 2'd0; m_boot[i] = 32'h0; m_cyc[i] = 32'h0;
        end
        m_is = '0; m_ie = '0; m_irq = 1'b0;

        repeat (3) @(negedge clk_i);
        check_eq("rst_core_rst_no", 64'(core_rst_no), 64'h0);
        check_eq("rst_boot_addr", boot_addr_o, 64'h0);
        check_eq("rst_irq", 64'(irq_o), 64'h0);
        check_eq("rst_d_valid", 64'(tl_o.d_valid), 64'h0);
        check_eq("rst_a_ready", 64'(tl_o.a_ready), 64'h1);
        rst_ni = 1'b1;

        rd32(12'h004, d);
        check_eq("status_reset", 64'(d), 64'h0);

        // Boot address programming and start of core 1
        wr32(12'h014, 32'h0001_0003);
        rd32(12'h014, d);
        check_eq("boot1_readback", 64'(d), 64'h0001_0000);
        check_eq("boot1_port", 64'(boot_addr_o[63:32]), 64'h0001_0000);
        wr32(12'h000, 32'h0000_0002);
        check_eq("core1_released", 64'(core_rst_no), 64'h2);
        rd32(12'h004, d);
        check_eq("status_running", 64'(d), 64'h4);

        // Completion raises interrupt; W1C clears it without touching STATUS
        wr32(12'h00C, 32'h0000_0003);
        tick(2'b10);
        tick(2'b00);
        rd32(12'h004, d);
        check_eq("status_done", 64'(d), 64'h8);
        check_eq("core1_held", 64'(core_rst_no), 64'h0);
        check_eq("irq_set", 64'(irq_o), 64'h1);
        wr32(12'h008, 32'h0000_0002);
        check_eq("irq_cleared", 64'(irq_o), 64'h0);
        rd32(12'h004, d);
        check_eq("status_after_w1c", 64'(d), 64'h8);

        // Abort coincident with done: abort wins, no interrupt
        wr32(12'h000, 32'h0000_0001);
        xfer(3'd0, 12'h000, 32'h0000_0100, 4'hF, 2'd2, 2'b01, 0, d, e);
        rd32(12'h004, d);
        check_eq("abort_beats_done", 64'(d), 64'h8);
        rd32(12'h008, d);
        check_eq("no_intr_on_abort", 64'(d), 64'h0);
        check_eq("irq_after_abort", 64'(irq_o), 64'h0);

        // Error responses with held d_valid
        xfer(3'd4, 12'h040, 32'h0, 4'hF, 2'd2, 2'b00, 3, d, e);
        check_eq("err_unmapped", 64'(e), 64'h1);
        xfer(3'd1, 12'h00C, 32'h0, 4'h3, 2'd2, 2'b00, 2, d, e);
        check_eq("err_partial_mask", 64'(e), 64'h1);
        rd32(12'h00C, d);
        check_eq("ien_unchanged", 64'(d), 64'h3);
        xfer(3'd4, 12'h004, 32'h0, 4'hF, 2'd1, 2'b00, 2, d, e);
        check_eq("err_size", 64'(e), 64'h1);

`ifdef MULTICORE_CTRL_CYCLE_CNT_EN
        // Cycle counter: 100 running cycles, then restart clears it
        wr32(12'h000, 32'h0000_0001);
        repeat (98) tick(2'b00);
        tick(2'b01);
        rd32(12'h020, d);
        check_eq("cycles_100", 64'(d), 64'd100);
        wr32(12'h000, 32'h0000_0001);
        rd32(12'h020, d);
        check_eq("cycles_restart_small", 64'(d <= 32'd2), 64'd1);
        repeat (10) tick(2'b00);
        rd32(12'h020, d);
        wr32(12'h000, 32'h0000_0100);
`endif

        // Randomized register traffic with random completion activity
        for (int n = 0; n < 300; n++) begin
            off  = offs[$urandom_range(0, 10)];
            case ($urandom_range(0, 2))
                0:       op = 3'd0;
                1:       op = 3'd1;
                default: op = 3'd4;
            endcase
            mask = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            sz   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd2;
            wd   = $urandom;
            if (off == 12'h000) begin
                wd = wd & 32'h0000_0303;
                if ($urandom_range(0, 1) == 1) wd = wd & 32'h0000_0003;
            end
            xfer(op, off, wd, mask, sz, rand_done(), $urandom_range(0, 2), d, e);
            repeat ($urandom_range(0, 2)) tick(rand_done());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
